mc_main_fsm: RTL and testbench
==============================

Name: mc_main_fsm

Overview:
- Moore-style main control FSM for the multicycle MIPS core.
- Sequences the shared datapath: PC, instruction/data memory port, IR, register file and ALU.
- Decodes the instruction opcode into per-cycle control strobes and the 2-bit alu_op. alu_op feeds the ALU-function decoder, which produces alu_control.
- Adds a memory-ready handshake so multi-cycle memories stall the sequence.

Parameters:
- MEM_HANDSHAKE, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is ignored and treated as 1.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- op  input  6  instruction opcode IR[31:26]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- pc_en  output  1  PC load = pc_write | (branch & branch_taken)
- mem_req  output  1  memory access active
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load
- reg_write  output  1  register-file write
- i_or_d  output  1  address select: 0 = PC, 1 = ALUOut
- mem_to_reg  output  1  write-back data select: 1 = MDR
- reg_dst  output  1  destination select: 1 = rd
- alu_src_a  output  1  0 = PC, 1 = A
- alu_src_b  output  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pc_src  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- alu_op  output  2  00 add, 01 sub, 10 funct
- illegal_op  output  1  pulses for one cycle in DECODE on an unknown opcode

Behaviour:
- State register is updated on posedge clk.
- While reset=1: next state is FETCH, and all write/strobe outputs are forced to 0 combinationally.
- Reset values of the other outputs: alu_src_b=01, all other selects 0, alu_op=00.
- Reset asserted mid-instruction abandons the instruction. No partial writes occur after the reset edge.
- States and transitions:
  - FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. Stays in FETCH while !mem_ready. When mem_ready: ir_write=1, pc_write=1, go to DECODE. ir_write and pc_write are asserted only in the mem_ready cycle.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - otherwise illegal_op=1 and go to FETCH (instruction treated as nop).
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_req=1, i_or_d=1. Waits for mem_ready, then -> MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEMWR: mem_req=1, i_or_d=1, mem_write=1. mem_write is held until mem_ready, then -> FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, branch_taken=zero -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - JUMP: pc_src=10, pc_write=1 -> FETCH.
- Latency with mem_ready tied to 1 (cycles, FETCH to next FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each extra !mem_ready cycle adds one.
- Every output not listed for a state is 0, except alu_src_b which defaults to 00.
- mem_ready outside memory states is ignored.
- pc_en is combinational from the state and zero.

Optional Feature:
- Macro MC_MAIN_FSM_BNE_EN.
- Defined: opcode 000101 (bne) decodes to BRANCH with branch_taken = ~zero. A one-bit flag latched in DECODE selects the polarity.
- Undefined: 000101 is illegal (illegal_op=1, return to FETCH).

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - alu_src_b and pc_src encodings
  - state enum typedef (4-bit).
- Natural sub-module: mc_next_state (combinational next-state/opcode decode). The output decode and state register stay in the top module.

Test Plan:
- Reset mid-MEMWR (reset=1 for 1 cycle) -> mem_write=0 on that cycle, state FETCH next; no memory write observed.
- lw (op=100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 with mem_to_reg=1 only in cycle 5; alu_op 00 throughout.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> 10 cycles total; ir_write pulses exactly once.
- beq with zero=1 -> pc_en=1 in cycle 3 with pc_src=01 and alu_op=01; with zero=0 -> pc_en=0 in cycle 3 (pc_en=1 only in the FETCH cycle).
- R-type then j back-to-back -> alu_op=10 in EXECUTE, reg_dst=1 in ALUWB, then 3-cycle j with pc_src=10 and pc_en=1.
- op=000101 -> with MC_MAIN_FSM_BNE_EN, zero=0 takes the branch (pc_en=1 in BRANCH); without it, illegal_op=1 in DECODE and the next state is FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes,
// ALU-operation codes, datapath mux encodings and the main FSM state type.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALURES = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_e;

endpackage

// File: rtl/mc_main_fsm_next_state.sv
// Combinational next-state and opcode decode for the main control FSM.
// Optional macro MC_MAIN_FSM_BNE_EN makes bne a legal branch opcode.
module mc_next_state
   import mips_pkg::*;
(
   input  state_e     state_i,
   input  logic [5:0] op_i,
   input  logic       ready_i,
   output state_e     state_o,
   output logic       illegal_o
);

   // Next-state selection; memory states hold until the access completes.
   always_comb begin
      state_o   = S_FETCH;
      illegal_o = 1'b0;
      case (state_i)
         S_FETCH: begin
            if (ready_i) state_o = S_DECODE;
            else         state_o = S_FETCH;
         end
         S_DECODE: begin
            case (op_i)
               OP_LW, OP_SW: state_o = S_MEMADR;
               OP_RTYPE:     state_o = S_EXECUTE;
               OP_BEQ:       state_o = S_BRANCH;
`ifdef MC_MAIN_FSM_BNE_EN
               OP_BNE:       state_o = S_BRANCH;
`endif
               OP_ADDI:      state_o = S_ADDIEX;
               OP_J:         state_o = S_JUMP;
               default: begin
                  // Unknown opcode: flag it and retire the instruction as a nop.
                  state_o   = S_FETCH;
                  illegal_o = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            if (op_i == OP_SW) state_o = S_MEMWR;
            else               state_o = S_MEMRD;
         end
         S_MEMRD: begin
            if (ready_i) state_o = S_MEMWB;
            else         state_o = S_MEMRD;
         end
         S_MEMWR: begin
            if (ready_i) state_o = S_FETCH;
            else         state_o = S_MEMWR;
         end
         S_EXECUTE: state_o = S_ALUWB;
         S_ADDIEX:  state_o = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_o = S_FETCH;
         default:   state_o = S_FETCH;
      endcase
   end

endmodule

// File: rtl/mc_main_fsm.sv
// Moore main control FSM of the multicycle MIPS core. Outputs decode from
// the state register; only the memory-completion strobes (ir_write, the
// FETCH pc_write) and pc_en additionally look at mem_ready / zero.
// Optional macro MC_MAIN_FSM_BNE_EN adds bne (branch on ~zero).
module mc_main_fsm
   import mips_pkg::*;
#(
   parameter int MEM_HANDSHAKE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       mem_req,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       i_or_d,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [1:0] alu_op,
   output logic       illegal_op
);

   state_e state_q;
   state_e state_d;
   logic   illegal_s;
   logic   ready_s;
   logic   pc_write_s;
   logic   branch_s;
   logic   taken_s;

   // With the handshake disabled every memory access completes in one cycle.
   assign ready_s = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

   mc_next_state u_next_state (
      .state_i   (state_q),
      .op_i      (op),
      .ready_i   (ready_s),
      .state_o   (state_d),
      .illegal_o (illegal_s)
   );

`ifdef MC_MAIN_FSM_BNE_EN
   logic bne_q;

   // State register plus branch-polarity flag captured while decoding.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         bne_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) bne_q <= (op == OP_BNE);
      end
   end

   assign taken_s = bne_q ? ~zero : zero;
`else
   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign taken_s = zero;
`endif

   // Per-state control decode; reset overrides everything so no write escapes.
   always_comb begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      i_or_d     = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      pc_src     = PCSRC_ALURES;
      alu_op     = ALUOP_ADD;
      illegal_op = 1'b0;
      pc_write_s = 1'b0;
      branch_s   = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            ir_write   = ready_s;
            pc_write_s = ready_s;
         end
         S_DECODE: begin
            alu_src_b  = SRCB_IMMSH2;
            illegal_op = illegal_s;
         end
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_req   = 1'b1;
            i_or_d    = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            pc_src    = PCSRC_ALUOUT;
            branch_s  = 1'b1;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         S_JUMP: begin
            pc_src     = PCSRC_JUMP;
            pc_write_s = 1'b1;
         end
         default: begin
            alu_src_b = SRCB_REG;
         end
      endcase
      if (reset) begin
         mem_req    = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         i_or_d     = 1'b0;
         mem_to_reg = 1'b0;
         reg_dst    = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = SRCB_FOUR;
         pc_src     = PCSRC_ALURES;
         alu_op     = ALUOP_ADD;
         illegal_op = 1'b0;
         pc_write_s = 1'b0;
         branch_s   = 1'b0;
      end else begin
         illegal_op = illegal_op;
      end
      pc_en = pc_write_s | (branch_s & taken_s);
   end

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed testbench for mc_main_fsm. Outputs are packed into one 16-bit
// word per cycle and compared with hand-derived per-state values:
// [15]pc_en [14]mem_req [13]mem_write [12]ir_write [11]reg_write [10]i_or_d
// [9]mem_to_reg [8]reg_dst [7]alu_src_a [6:5]alu_src_b [4:3]pc_src
// [2:1]alu_op [0]illegal_op
module tb_mc_main_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, mem_req, mem_write, ir_write, reg_write, i_or_d;
   logic       mem_to_reg, reg_dst, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, pc_src, alu_op;
   logic [15:0] outs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign outs = {pc_en, mem_req, mem_write, ir_write, reg_write, i_or_d,
                  mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_src, alu_op,
                  illegal_op};

   mc_main_fsm dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_en      (pc_en),
      .mem_req    (mem_req),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .i_or_d     (i_or_d),
      .mem_to_reg (mem_to_reg),
      .reg_dst    (reg_dst),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_src     (pc_src),
      .alu_op     (alu_op),
      .illegal_op (illegal_op)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; op = 6'b101011; zero = 1'b0; mem_ready = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if (outs !== 16'h0020) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h", outs, 16'h0020);
      end
      step();
      reset = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== 16'h4020) begin
         errors++;
         $display("FAIL reset_to_fetch: got %h expected %h", outs, 16'h4020);
      end
      step();
   endtask

   task automatic test_lw();
      logic [15:0] exp [5];
      exp = '{16'hD020, 16'h0060, 16'h00C0, 16'h4400, 16'h0A00};
      op = 6'b100011;
      for (int i = 0; i < 5; i++) begin
         mem_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL lw cycle %0d: got %h expected %h", i, outs, exp[i]);
         end
         step();
      end
   endtask

   task automatic test_lw_stall();
      logic [15:0] exp [10];
      logic        rdy [10];
      int          ir_cnt = 0;
      exp = '{16'h4020, 16'h4020, 16'hD020, 16'h0060, 16'h00C0,
              16'h4400, 16'h4400, 16'h4400, 16'h4400, 16'h0A00};
      rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      op = 6'b100011;
      for (int i = 0; i < 10; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         if (ir_write === 1'b1) ir_cnt++;
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL lw_stall cycle %0d: got %h expected %h", i, outs, exp[i]);
         end
         step();
      end
      checks++;
      if (ir_cnt !== 1) begin
         errors++;
         $display("FAIL lw_stall_ir_pulses: got %0d expected 1", ir_cnt);
      end
   endtask

   task automatic test_sw();
      logic [15:0] exp [5];
      logic        rdy [5];
      exp = '{16'hD020, 16'h0060, 16'h00C0, 16'h6400, 16'h6400};
      rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      op = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL sw cycle %0d: got %h expected %h", i, outs, exp[i]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_memwr();
      logic [15:0] exp [6];
      logic        rdy [6];
      logic        rst [6];
      exp = '{16'hD020, 16'h0060, 16'h00C0, 16'h6400, 16'h0020, 16'h4020};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      op = 6'b101011;
      for (int i = 0; i < 6; i++) begin
         mem_ready = rdy[i];
         reset     = rst[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL reset_mid_memwr cycle %0d: got %h expected %h", i, outs, exp[i]);
         end
         step();
      end
   endtask

   task automatic test_beq();
      logic [15:0] exp [6];
      logic        zr  [6];
      exp = '{16'hD020, 16'h0060, 16'h808A, 16'hD020, 16'h0060, 16'h008A};
      zr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      op = 6'b000100;
      for (int i = 0; i < 6; i++) begin
         zero = zr[i];
         mem_ready = (i == 1) ? 1'b0 : 1'b1;
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL beq cycle %0d: got %h expected %h", i, outs, exp[i]);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp [7];
      logic [5:0]  ops [7];
      exp = '{16'hD020, 16'h0060, 16'h0084, 16'h0900, 16'hD020, 16'h0060, 16'h8010};
      ops = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000010, 6'b000010, 6'b000010};
      for (int i = 0; i < 7; i++) begin
         op = ops[i];
         mem_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", i, outs, exp[i]);
         end
         step();
      end
   endtask

   task automatic test_addi();
      logic [15:0] exp [4];
      exp = '{16'hD020, 16'h0060, 16'h00C0, 16'h0800};
      op = 6'b001000;
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL addi cycle %0d: got %h expected %h", i, outs, exp[i]);
         end
         step();
      end
   endtask

   task automatic test_bne();
`ifdef MC_MAIN_FSM_BNE_EN
      logic [15:0] exp [6];
      logic        zr  [6];
      exp = '{16'hD020, 16'h0060, 16'h808A, 16'hD020, 16'h0060, 16'h008A};
      zr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      op = 6'b000101;
      for (int i = 0; i < 6; i++) begin
         zero = zr[i];
         mem_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL bne cycle %0d: got %h expected %h", i, outs, exp[i]);
         end
         step();
      end
`else
      logic [15:0] exp [3];
      exp = '{16'hD020, 16'h0061, 16'h4020};
      op = 6'b000101;
      zero = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_ready = (i == 2) ? 1'b0 : 1'b1;
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL bne_illegal cycle %0d: got %h expected %h", i, outs, exp[i]);
         end
         step();
      end
`endif
   endtask

   task automatic test_illegal();
      logic [15:0] exp [3];
      exp = '{16'hD020, 16'h0061, 16'h4020};
      op = 6'b111111;
      for (int i = 0; i < 3; i++) begin
         mem_ready = (i == 2) ? 1'b0 : 1'b1;
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL illegal cycle %0d: got %h expected %h", i, outs, exp[i]);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lw_stall();
      test_sw();
      test_reset_mid_memwr();
      test_beq();
      test_back_to_back();
      test_addi();
      test_bne();
      test_illegal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
